// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill controller.
// Reads LINE_WORDS words from backing memory and hands the line to the cache.
module icache_refill_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int WORD_W     = 16,
  parameter int LINE_WORDS = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_req,
  input  logic [ADDR_W-1:0]        miss_addr,
  input  logic                     flush,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [WORD_W-1:0]        mem_rdata,
  input  logic                     mem_rvalid,
  output logic                     fill_valid,
  output logic [ADDR_W-1:0]        fill_addr,
  output logic [LINE_WORDS*WORD_W-1:0] fill_line,
  output logic                     stall,
  output logic                     err
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int LINE_W = LINE_WORDS * WORD_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, FILL, DRAIN, COOL
  } state_t;

  state_t              stateQ, stateD;
  logic [ADDR_W-1:0]   baseQ, baseD;
  logic [CNT_W-1:0]    cntQ, cntD;
  logic [TMO_W-1:0]    tmoQ, tmoD;
  logic [LINE_W-1:0]   lineQ, lineD;
  logic                errQ, errD;
  logic                unusedBits;

  assign unusedBits = ^miss_addr[CNT_W-1:0];

  // State and datapath registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ <= IDLE;
      baseQ  <= '0;
      cntQ   <= '0;
      tmoQ   <= '0;
      lineQ  <= '0;
      errQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      baseQ  <= baseD;
      cntQ   <= cntD;
      tmoQ   <= tmoD;
      lineQ  <= lineD;
      errQ   <= errD;
    end
  end

  // Next-state logic: request/wait per word, fill, then one cool-down cycle
  always_comb begin
    stateD = stateQ;
    baseD  = baseQ;
    cntD   = cntQ;
    tmoD   = tmoQ;
    lineD  = lineQ;
    errD   = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (miss_req && !flush) begin
          baseD  = {miss_addr[ADDR_W-1:CNT_W], {CNT_W{1'b0}}};
          cntD   = '0;
          stateD = REQ;
        end
      end
      REQ: begin
        if (flush) begin
          stateD = IDLE;
        end else begin
          tmoD   = '0;
          stateD = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          if (flush) begin
            stateD = IDLE;
          end else begin
            lineD[cntQ*WORD_W +: WORD_W] = mem_rdata;
            if (cntQ == CNT_LAST) begin
              stateD = FILL;
            end else begin
              cntD   = cntQ + 1'b1;
              stateD = REQ;
            end
          end
        end else if (flush) begin
          tmoD   = tmoQ + 1'b1;
          stateD = DRAIN;
        end else if (tmoQ == TMO_LAST) begin
          errD   = 1'b1;
          stateD = IDLE;
        end else begin
          tmoD = tmoQ + 1'b1;
        end
      end
      FILL: stateD = COOL;
      DRAIN: begin
        if (mem_rvalid || tmoQ >= TMO_LAST) begin
          stateD = IDLE;
        end else begin
          tmoD = tmoQ + 1'b1;
        end
      end
      COOL: stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Outputs decoded from state; the read strobe is suppressed by flush
  always_comb begin
    mem_rd_en  = (stateQ == REQ) && !flush;
    mem_addr   = baseQ + ADDR_W'(cntQ);
    fill_valid = (stateQ == FILL);
    fill_addr  = baseQ;
    fill_line  = lineQ;
    err        = errQ;
    stall      = (miss_req && stateQ == IDLE) ||
                 (stateQ == REQ) || (stateQ == WAIT) ||
                 (stateQ == FILL) || (stateQ == DRAIN);
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Testbench for icache_refill_ctrl.
// Memory model, scoreboard of expected fills/errors, directed and random misses.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_req;
  logic [15:0] miss_addr;
  logic        flush;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        fill_valid;
  logic [15:0] fill_addr;
  logic [63:0] fill_line;
  logic        stall;
  logic        err;

  icache_refill_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .flush(flush),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_valid(fill_valid), .fill_addr(fill_addr),
    .fill_line(fill_line), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          isErr;
    logic [15:0] addr;
    logic [63:0] line;
  } ev_t;

  ev_t         sb[$];
  logic [15:0] expAddrQ[$];
  int          latQ[$];
  bit          fixedData = 0;
  bit          noResp = 0;
  bit          strayReq = 0;
  logic [15:0] salt = 16'h0;
  int          fillsSeen = 0;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    if (fixedData) return 16'h1111 * (16'(a[1:0]) + 16'd1);
    return (a * 16'h9E37) ^ salt;
  endfunction

  function automatic logic [63:0] refLine(input logic [15:0] a);
    logic [63:0] l;
    logic [15:0] b;
    b = a & 16'hFFFC;
    for (int i = 0; i < 4; i++) l[16*i +: 16] = memWord(b + 16'(i));
    return l;
  endfunction

  bit          busy = 0;
  int          due = 0;
  logic [15:0] pAddr = 16'h0;

  // backing memory: one outstanding read, latency from latQ or random
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0;
    forever begin
      @(negedge clk);
      if (mem_rd_en) begin
        check("rd_overlap", 64'(busy), 64'd0);
        check("rd_expected", 64'(expAddrQ.size() > 0), 64'd1);
        if (expAddrQ.size() > 0) check("mem_addr", 64'(mem_addr), 64'(expAddrQ.pop_front()));
        if (!noResp) begin
          busy  = 1;
          pAddr = mem_addr;
          due   = cyc + ((latQ.size() > 0) ? latQ.pop_front() : int'($urandom_range(1, 6)));
        end
      end
      @(posedge clk);
      #1;
      if (busy && cyc == due) begin
        mem_rvalid = 1'b1;
        mem_rdata  = memWord(pAddr);
        busy = 0;
      end else if (strayReq) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 16'($urandom);
        strayReq = 0;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 16'($urandom);
      end
    end
  end

  // monitor: compare each fill/err pulse with the scoreboard head
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (fill_valid || err) begin
        check("event_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("evt_err", 64'(err), 64'(e.isErr));
          check("evt_fill", 64'(fill_valid), 64'(!e.isErr));
          if (!e.isErr) begin
            check("fill_addr", 64'(fill_addr), 64'(e.addr));
            check("fill_line", fill_line, e.line);
          end
        end
        if (fill_valid) fillsSeen++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitRd(input logic [15:0] a);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (mem_rd_en && mem_addr == a) ok = 1;
    end
    check("wait_rd", 64'(ok), 64'd1);
  endtask

  task automatic waitEvent();
    bit ok;
    ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (fill_valid || err) ok = 1;
    end
    check("wait_event", 64'(ok), 64'd1);
  endtask

  task automatic expectLine(input logic [15:0] a, input int nAddr);
    ev_t e;
    e.isErr = 0;
    e.addr  = a & 16'hFFFC;
    e.line  = refLine(a);
    sb.push_back(e);
    for (int i = 0; i < nAddr; i++) expAddrQ.push_back(e.addr + 16'(i));
  endtask

  task automatic doMiss(input logic [15:0] a);
    expectLine(a, 4);
    miss_req  = 1'b1;
    miss_addr = a;
    waitEvent();
    tick();
    miss_req = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_fill_valid"}, 64'(fill_valid), 64'd0);
    check({tag, "_fill_addr"}, 64'(fill_addr), 64'd0);
    check({tag, "_fill_line"}, fill_line, 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_stall"}, 64'(stall), 64'd0);
  endtask

  initial begin
    int   startCyc;
    int   rdCyc;
    int   fills0;
    bit   done;
    ev_t  e;
    logic [15:0] a;

    rst_n = 1'b0; miss_req = 1'b0; miss_addr = 16'h0; flush = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checkAllZero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // basic refill, fixed data, 1-cycle latency
    fixedData = 1;
    latQ = {1, 1, 1, 1};
    expectLine(16'h0012, 4);
    miss_req = 1'b1;
    miss_addr = 16'h0012;
    @(negedge clk);
    startCyc = cyc;
    check("stall_miss_idle", 64'(stall), 64'd1);
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      check("stall_busy", 64'(stall), 64'd1);
      if (fill_valid) done = 1;
    end
    check("fill_seen", 64'(done), 64'd1);
    check("fill_latency", 64'(cyc - startCyc), 64'd9);
    tick();
    @(negedge clk);
    check("stall_cool", 64'(stall), 64'd0);
    check("fill_pulse", 64'(fill_valid), 64'd0);
    tick();
    miss_req = 1'b0;
    @(negedge clk);
    check("stall_idle", 64'(stall), 64'd0);
    tick();

    // variable latency, same line
    latQ = {1, 4, 8, 2};
    doMiss(16'h0012);
    tick();

    // top-of-memory line
    fixedData = 0;
    salt = 16'($urandom);
    latQ = {1, 2, 1, 3};
    doMiss(16'hFFFE);
    tick();

    // flush while word 2 is outstanding
    salt = 16'($urandom);
    latQ = {1, 1, 7};
    fills0 = fillsSeen;
    for (int i = 0; i < 3; i++) expAddrQ.push_back(16'h0024 + 16'(i));
    miss_req = 1'b1;
    miss_addr = 16'h0027;
    waitRd(16'h0026);
    tick();
    flush = 1'b1;
    miss_req = 1'b0;
    @(negedge clk);
    check("stall_flush_wait", 64'(stall), 64'd1);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("stall_drain", 64'(stall), 64'd1);
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1;
    end
    check("drain_exit", 64'(done), 64'd1);
    check("drain_consumed", 64'(busy), 64'd0);
    check("drain_no_fill", 64'(fillsSeen), 64'(fills0));
    check("drain_addrq", 64'(expAddrQ.size()), 64'd0);
    tick();
    salt = 16'($urandom);
    doMiss(16'h0040);
    tick();

    // memory never answers
    noResp = 1;
    e.isErr = 1; e.addr = 16'h0100; e.line = 64'h0;
    sb.push_back(e);
    expAddrQ.push_back(16'h0100);
    fills0 = fillsSeen;
    miss_req = 1'b1;
    miss_addr = 16'h0101;
    waitRd(16'h0100);
    rdCyc = cyc;
    tick();
    miss_req = 1'b0;
    @(negedge clk);
    check("stall_wait_to", 64'(stall), 64'd1);
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (err) done = 1;
    end
    check("err_seen", 64'(done), 64'd1);
    check("err_latency", 64'(cyc - rdCyc), 64'd256);
    check("stall_after_err", 64'(stall), 64'd0);
    @(negedge clk);
    check("err_pulse", 64'(err), 64'd0);
    check("to_no_fill", 64'(fillsSeen), 64'(fills0));
    noResp = 0;
    tick();

    // reset during wait of word 1, then a stray rvalid
    salt = 16'($urandom);
    latQ = {1, 9};
    for (int i = 0; i < 2; i++) expAddrQ.push_back(16'h0200 + 16'(i));
    miss_req = 1'b1;
    miss_addr = 16'h0200;
    waitRd(16'h0201);
    tick();
    rst_n = 1'b0;
    miss_req = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checkAllZero("midreset");
    repeat (12) tick();
    strayReq = 1;
    repeat (3) tick();
    @(negedge clk);
    checkAllZero("stray");
    check("stray_busy", 64'(busy), 64'd0);
    tick();

    // random misses
    for (int n = 0; n < 25; n++) begin
      salt = 16'($urandom);
      a = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = a | 16'hFFF0;
      for (int i = 0; i < 4; i++) latQ.push_back(int'($urandom_range(1, 8)));
      doMiss(a);
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (5) tick();
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("addrq_empty", 64'(expAddrQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
